// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-time benchmark: FSM state encodings and
// the default timing constants used by both the controller and the datapath top.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'b000,
        ST_ARM         = 3'b001,
        ST_GO          = 3'b010,
        ST_RESULT      = 3'b011,
        ST_FALSE_START = 3'b100,
        ST_TIMEOUT     = 3'b101
    } state_t;

    // 50 MHz clock: 10 ms debounce, 4095 us-ticks of 50 cycles for timeout
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_START_HOLD      = 100;
    localparam int DEF_ARM_GUARD       = 100;
    localparam int DEF_LOAD_HOLD       = 2;
    localparam int DEF_TIMEOUT_CYCLES  = 204750;
    localparam int DEF_TW              = 18;

    localparam int VALID_W = 8;

endpackage

// File: rtl/reaction_ctrl_button.sv
// Player-button conditioner: two-flop synchroniser, stable-count debounce and a
// single-cycle press event on the debounced rising edge. Reusable by other games.
module button_conditioner
    import reaction_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic iReset,
    input  logic button,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (iReset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= button;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // Any sample matching the current level restarts the stability count
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
                press <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time trial sequencer: arms the random delay, lights the go screen,
// and classifies the outcome as a valid result, a false start or a timeout.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int START_HOLD      = DEF_START_HOLD,
    parameter int ARM_GUARD       = DEF_ARM_GUARD,
    parameter int LOAD_HOLD       = DEF_LOAD_HOLD,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int TW              = DEF_TW
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iButton,
    input  logic       iCountComplete,
    output logic       oStart_down_count,
    output logic       oStart_up_count,
    output logic       oLoad_score,
    output logic       oScreen,
    output logic       oFalseStart,
    output logic       oTimeout,
    output logic       oResultValid,
    output logic [7:0] oValidCount,
    output logic [2:0] oState
);

    localparam logic [TW-1:0] T_START   = TW'(START_HOLD);
    localparam logic [TW-1:0] T_GUARD   = TW'(START_HOLD + ARM_GUARD);
    localparam logic [TW-1:0] T_LOAD    = TW'(LOAD_HOLD);
    localparam logic [TW-1:0] T_TO      = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX     = '1;

    function automatic logic [VALID_W-1:0] sat_inc(input logic [VALID_W-1:0] v);
        return (v == {VALID_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic press;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;

    logic               down_nxt;
    logic               up_nxt;
    logic               load_nxt;
    logic               screen_nxt;
    logic               false_nxt;
    logic               timeout_nxt;
    logic               result_nxt;
    logic [VALID_W-1:0] count_nxt;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .iReset(iReset),
        .button(iButton),
        .press (press)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (press) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                // Early countComplete is the stale zero from before the reload
                if (press)
                    state_nxt = ST_FALSE_START;
                else if (iCountComplete && (timer >= T_GUARD))
                    state_nxt = ST_GO;
            end
            ST_GO: begin
                if (press)
                    state_nxt = (timer < T_START) ? ST_FALSE_START : ST_RESULT;
                else if (timer == T_TO_LAST)
                    state_nxt = ST_TIMEOUT;
            end
            ST_RESULT: begin
                if (press && (timer >= T_LOAD)) state_nxt = ST_ARM;
            end
            ST_FALSE_START, ST_TIMEOUT: begin
                if (press) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (state_nxt != state)
            timer_nxt = '0;
        else if (state == ST_GO)
            timer_nxt = (timer >= T_TO) ? T_TO : timer + 1'b1;
        else
            timer_nxt = (timer == T_MAX) ? timer : timer + 1'b1;

        // Outputs are decoded from the next state/timer so the registers line up with the state
        down_nxt    = (state_nxt == ST_ARM)    && (timer_nxt < T_START);
        up_nxt      = (state_nxt == ST_GO)     && (timer_nxt < T_START);
        load_nxt    = (state_nxt == ST_RESULT) && (timer_nxt < T_LOAD);
        screen_nxt  = (state_nxt == ST_GO);
        false_nxt   = (state_nxt == ST_FALSE_START);
        timeout_nxt = (state_nxt == ST_TIMEOUT);
        result_nxt  = (state_nxt == ST_RESULT);
        count_nxt   = ((state_nxt == ST_RESULT) && (state != ST_RESULT)) ?
                      sat_inc(oValidCount) : oValidCount;
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state             <= ST_IDLE;
            timer             <= '0;
            oStart_down_count <= 1'b0;
            oStart_up_count   <= 1'b0;
            oLoad_score       <= 1'b0;
            oScreen           <= 1'b0;
            oFalseStart       <= 1'b0;
            oTimeout          <= 1'b0;
            oResultValid      <= 1'b0;
            oValidCount       <= '0;
        end else begin
            state             <= state_nxt;
            timer             <= timer_nxt;
            oStart_down_count <= down_nxt;
            oStart_up_count   <= up_nxt;
            oLoad_score       <= load_nxt;
            oScreen           <= screen_nxt;
            oFalseStart       <= false_nxt;
            oTimeout          <= timeout_nxt;
            oResultValid      <= result_nxt;
            oValidCount       <= count_nxt;
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with short debounce/hold/timeout parameters;
// expected values are hand-derived cycle counts from each state entry.
module tb_reaction_ctrl;

    logic       clk = 1'b0;
    logic       iReset;
    logic       iButton;
    logic       iCountComplete;
    logic       oStart_down_count;
    logic       oStart_up_count;
    logic       oLoad_score;
    logic       oScreen;
    logic       oFalseStart;
    logic       oTimeout;
    logic       oResultValid;
    logic [7:0] oValidCount;
    logic [2:0] oState;

    int n_cmp = 0;
    int n_mis = 0;

    reaction_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .START_HOLD     (50),
        .ARM_GUARD      (100),
        .LOAD_HOLD      (2),
        .TIMEOUT_CYCLES (1000),
        .TW             (18)
    ) dut (
        .clk              (clk),
        .iReset           (iReset),
        .iButton          (iButton),
        .iCountComplete   (iCountComplete),
        .oStart_down_count(oStart_down_count),
        .oStart_up_count  (oStart_up_count),
        .oLoad_score      (oLoad_score),
        .oScreen          (oScreen),
        .oFalseStart      (oFalseStart),
        .oTimeout         (oTimeout),
        .oResultValid     (oResultValid),
        .oValidCount      (oValidCount),
        .oState           (oState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press becomes visible 6 edges after the raw edge; the FSM acts on the 7th
    task automatic push();
        iButton = 1'b1;
        tick(7);
        iButton = 1'b0;
    endtask

    int bounce_press;
    int press_cnt, press_at, arm_at, go_at;
    int down_n, down_first, up_n, scr_n, load_n;

    initial begin
        iReset         = 1'b1;
        iButton        = 1'b0;
        iCountComplete = 1'b0;
        tick(3);
        chk("rst_state",   oState, 0);
        chk("rst_down",    oStart_down_count, 0);
        chk("rst_up",      oStart_up_count, 0);
        chk("rst_load",    oLoad_score, 0);
        chk("rst_screen",  oScreen, 0);
        chk("rst_fs",      oFalseStart, 0);
        chk("rst_to",      oTimeout, 0);
        chk("rst_rv",      oResultValid, 0);
        chk("rst_count",   oValidCount, 0);
        iReset = 1'b0;

        // Bounce, then a stable press: arm, guard, go
        iCountComplete = 1'b1;
        bounce_press = 0;
        for (int i = 0; i < 10; i++) begin
            iButton = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (dut.u_btn.press) bounce_press++;
            end
        end
        chk("bounce_no_press", bounce_press, 0);
        chk("bounce_idle", oState, 0);

        iButton = 1'b1;
        press_cnt = 0; press_at = -1; arm_at = -1; go_at = -1;
        down_n = 0; down_first = -1; up_n = 0; scr_n = 0;
        for (int c = 1; c <= 400; c++) begin
            tick(1);
            if (c == 20) iButton = 1'b0;
            if (dut.u_btn.press) begin
                press_cnt++;
                if (press_at < 0) press_at = c;
            end
            if (oState == 3'd1 && arm_at < 0) arm_at = c;
            if (oState == 3'd2 && go_at < 0) go_at = c;
            if (oStart_down_count) begin
                down_n++;
                if (down_first < 0) down_first = c;
            end
            if (oStart_up_count) up_n++;
            if (oScreen) scr_n++;
        end
        chk("press_count",   press_cnt, 1);
        chk("press_latency", press_at, 6);
        chk("arm_entry",     arm_at, 7);
        chk("down_first",    down_first, 7);
        chk("down_len",      down_n, 50);
        chk("go_entry",      go_at, 158);
        chk("up_len",        up_n, 50);
        chk("screen_len",    scr_n, 243);
        chk("go_state",      oState, 2);

        // Valid trial: press at GO timer 300
        tick(52);
        push();
        chk("valid_state",  oState, 3);
        chk("valid_rv",     oResultValid, 1);
        chk("valid_screen", oScreen, 0);
        chk("valid_count",  oValidCount, 1);
        load_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (oLoad_score) load_n++;
            tick(1);
        end
        chk("load_len", load_n, 2);

        // False start in ARM at timer 20, then back to IDLE
        push();
        chk("result_to_arm", oState, 1);
        tick(14);
        push();
        chk("arm_fs_state", oState, 4);
        chk("arm_fs_flag",  oFalseStart, 1);
        chk("arm_fs_load",  oLoad_score, 0);
        chk("arm_fs_count", oValidCount, 1);
        tick(8);
        push();
        chk("fs_idle_state", oState, 0);
        chk("fs_idle_fs",    oFalseStart, 0);
        chk("fs_idle_to",    oTimeout, 0);
        chk("fs_idle_rv",    oResultValid, 0);

        // Anticipation in GO at timer 10
        tick(8);
        push();
        tick(151);
        chk("go2_state", oState, 2);
        tick(4);
        push();
        chk("go_fs_state", oState, 4);
        chk("go_fs_flag",  oFalseStart, 1);
        chk("go_fs_count", oValidCount, 1);
        tick(8);
        push();
        chk("go_fs_idle", oState, 0);

        // Timeout exactly 1000 cycles after GO entry
        tick(8);
        push();
        tick(151);
        chk("go3_state", oState, 2);
        tick(999);
        chk("to_999_state", oState, 2);
        chk("to_999_flag",  oTimeout, 0);
        tick(1);
        chk("to_state",  oState, 5);
        chk("to_flag",   oTimeout, 1);
        chk("to_screen", oScreen, 0);
        chk("to_load",   oLoad_score, 0);
        tick(8);
        push();
        chk("to_idle_state", oState, 0);
        chk("to_idle_flag",  oTimeout, 0);

        // Press on the last GO cycle wins over the timeout
        tick(8);
        push();
        tick(151);
        tick(993);
        push();
        chk("coinc_state", oState, 3);
        chk("coinc_to",    oTimeout, 0);
        chk("coinc_count", oValidCount, 2);

        // Reset during GO
        tick(8);
        push();
        tick(151);
        tick(5);
        chk("pre_rst_up", oStart_up_count, 1);
        iReset = 1'b1;
        tick(1);
        iReset = 1'b0;
        chk("mid_rst_state",  oState, 0);
        chk("mid_rst_up",     oStart_up_count, 0);
        chk("mid_rst_screen", oScreen, 0);
        chk("mid_rst_down",   oStart_down_count, 0);
        chk("mid_rst_load",   oLoad_score, 0);
        chk("mid_rst_rv",     oResultValid, 0);
        chk("mid_rst_count",  oValidCount, 0);

        // 256 valid trials, each pressed at GO timer 50
        tick(2);
        push();
        for (int i = 0; i < 256; i++) begin
            tick(151);
            tick(44);
            push();
            chk("sat_result", oState, 3);
            if (i == 254) chk("sat_255", oValidCount, 255);
            tick(8);
            push();
        end
        chk("sat_hold", oValidCount, 255);

        // Press at GO timer 49 is still anticipation
        tick(151);
        tick(43);
        push();
        chk("go49_state", oState, 4);
        chk("go49_count", oValidCount, 255);
        tick(8);
        push();
        chk("go49_idle", oState, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
